mem_copy_dma: RTL and testbench
===============================

# mem_copy_dma

- Bus-master copy engine that moves a block of 32-bit words between two regions of the shared word memory.
- Drives the same memory port the multi-cycle MIPS core uses: mem_addr, mem_read, mem_write, mem_write_data, mem_read_data.
- The memory is the asynchronous responder: read data is valid a fixed delay after address/read, and writes commit on posedge clk.
- The block issues one read and one write per word, with a configurable read wait. It is used for test-data setup and for future block-move support alongside the core.

## Interface

- READ_WAIT, 3, cycles mem_read is held per word before read data is captured (≥1; 3 covers 7 ns read delay at 2.5 ns clock)
- CNT_W, 10, width of word count (up to 1023 words)
- clk  input  1  system clock, all state on posedge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- start  input  1  request; sampled only in IDLE
- src_addr  input  32  byte address of first source word; bits [1:0] ignored
- dst_addr  input  32  byte address of first destination word; bits [1:0] ignored
- word_count  input  CNT_W  number of words to copy; sampled with start
- busy  output  1  high in READ and WRITE states
- done  output  1  one-cycle pulse in DONE state
- words_done  output  CNT_W  words written so far in current/last transfer
- mem_addr  output  32  word-aligned byte address ([1:0]=0)
- mem_read  output  1  read strobe
- mem_write  output  1  write strobe, committed by memory at next posedge
- mem_write_data  output  32  data for write
- mem_read_data  input  32  memory read data

## Operation

- FSM states: IDLE, READ, WRITE, DONE.
- IDLE
  - start=1 with word_count≠0 → latch src/dst ({addr[31:2],2'b00}) and count; clear words_done; go to READ.
  - start=1 with word_count=0 → clear words_done; go to DONE.
- READ
  - mem_read=1, mem_addr=src pointer.
  - Wait counter runs READ_WAIT cycles.
  - On the last cycle, capture mem_read_data into the data buffer; go to WRITE.
- WRITE
  - mem_write=1, mem_addr=dst pointer, mem_write_data=buffer. Lasts one cycle.
  - At the edge: src+=4, dst+=4, words_done+=1, remaining−=1.
  - remaining reaches 0 → DONE, else → READ.
- DONE: done=1 for one cycle, then IDLE.
- Strobes and address are decoded from registered state only, so they are glitch-free. mem_read and mem_write are never high together.
- Pointer arithmetic is mod 2^32 (0xFFFFFFFC+4 → 0x0). The memory decodes only addr[11:2], so 1024-word aliasing is the memory's behaviour, not this block's.
- Outside READ: mem_read=0. Outside WRITE: mem_write=0, mem_write_data holds the buffer.
- start while busy or in DONE is ignored; it is not queued.
- Overlapping regions: words are copied in ascending order, with no overlap handling.

## Timing

- Reset values: state=IDLE, busy=0, done=0, words_done=0, mem_read=0, mem_write=0, mem_addr=0, mem_write_data=0, buffer=0.
- start sampled at edge E0 → busy=1 and mem_read=1 after E0.
- Each word takes READ_WAIT+1 cycles.
- done is high for the cycle after edge E0+N·(READ_WAIT+1); this gives E0 for N=0.
- Read data is captured READ_WAIT cycles after mem_addr/mem_read become valid.
- Reset during a transfer aborts it at that edge: state→IDLE, all outputs at reset values, no done pulse.
  - A WRITE cycle coinciding with the reset edge is still committed by the memory, because the strobe was already registered.
  - No further accesses occur.
- Reset has priority over start in the same cycle.

## Configuration

- MEM_COPY_DMA_CHECKSUM_EN defined:
  - Adds output checksum[31:0]: sum mod 2^32 of every word written in the current transfer.
  - Cleared on reset and on an accepted start; updated at each WRITE edge.
  - Valid in DONE and held until the next start.
- Undefined: no checksum port and no adder; all other behaviour is identical.

## Test plan

- Basic copy, READ_WAIT=3:
  - Preload words 50..53 = 0x11,0x22,0x33,0x44.
  - Stimulus: start src=0xC8 dst=0x100 count=4.
  - Required: words 64..67 equal the source; done high exactly 16 cycles after the start edge; words_done=4; checksum=0xAA when enabled.
- Zero count:
  - Stimulus: start with count=0.
  - Required: done the next cycle; mem_read/mem_write never asserted; memory unchanged.
- Start while busy:
  - Stimulus: second start with different src/dst 5 cycles into a 2-word copy.
  - Required: ignored; only the first copy happens; one done pulse.
- Reset mid-operation:
  - Stimulus: assert reset during READ of word 2 of a 4-word copy.
  - Required: word 1 written, words 2..3 untouched, no done, all outputs at reset values the next cycle.
  - Then: a new start completes normally.
- Address wrap and unaligned input:
  - Stimulus: src=0xFFFFFFFB count=2.
  - Required: reads at 0xFFFFFFF8 then 0xFFFFFFFC. A 3-word copy from src=0xFFFFFFFC reads at 0xFFFFFFFC, then 0x0, then 0x4.
  - Required throughout: mem_addr[1:0]=0 always.
- Protocol checker, every run:
  - mem_read and mem_write never both high.
  - mem_read held exactly READ_WAIT cycles per word.
  - mem_write is a single-cycle pulse.

Source files
------------

// File: rtl/mem_copy_dma_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_copy_dma_if
// Description : Shared word-memory port between a bus master and the memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_copy_dma_if;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport master (
        output mem_addr,
        output mem_read,
        output mem_write,
        output mem_write_data,
        input  mem_read_data
    );

    modport slave (
        input  mem_addr,
        input  mem_read,
        input  mem_write,
        input  mem_write_data,
        output mem_read_data
    );
endinterface
`default_nettype wire

// File: rtl/mem_copy_dma.sv
`default_nettype none
// ============================================================================
// Module      : mem_copy_dma
// Description : Block copy engine on the shared word memory, one read and one
//               write per word. Define MEM_COPY_DMA_CHECKSUM_EN to add a
//               running sum of the written words on output checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_copy_dma #(
    parameter int READ_WAIT = 3,
    parameter int CNT_W     = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] words_done,
`ifdef MEM_COPY_DMA_CHECKSUM_EN
    output logic [31:0]      checksum,
`endif
    mem_copy_dma_if.master   mem
);

    localparam int                  c_WAIT_W    = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(READ_WAIT - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);
    localparam logic [CNT_W-1:0]    c_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]    c_CNT_ZERO  = '0;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [31:0]         r_src;
    logic [31:0]         r_dst;
    logic [31:0]         r_buffer;
    logic [CNT_W-1:0]    r_remaining;
    logic [CNT_W-1:0]    r_words_done;
    logic [c_WAIT_W-1:0] r_wait;

    logic                w_accept;
    logic                w_wait_last;
    logic                w_last_word;
    logic                w_mem_read;
    logic                w_mem_write;
    logic [31:0]         w_mem_addr;
    logic                w_unused_addr_lsbs;

    // Byte-lane bits of the start addresses are dropped on purpose.
    assign w_unused_addr_lsbs = ^{src_addr[1:0], dst_addr[1:0]};

    assign w_accept    = (r_state == c_IDLE) && start;
    assign w_wait_last = (r_wait == c_WAIT_LAST);
    assign w_last_word = (r_remaining == c_CNT_ONE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_next = (word_count != c_CNT_ZERO) ? c_READ : c_DONE;
                end
            end
            c_READ: begin
                if (w_wait_last) begin
                    w_state_next = c_WRITE;
                end
            end
            c_WRITE: begin
                w_state_next = w_last_word ? c_DONE : c_READ;
            end
            c_DONE: begin
                w_state_next = c_IDLE;
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: registered state and pointers only
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_mem_addr  = 32'd0;
        case (r_state)
            c_READ: begin
                w_mem_read = 1'b1;
                w_mem_addr = r_src;
            end
            c_WRITE: begin
                w_mem_write = 1'b1;
                w_mem_addr  = r_dst;
            end
            default: begin
                w_mem_addr = 32'd0;
            end
        endcase
    end

    assign mem.mem_read       = w_mem_read;
    assign mem.mem_write      = w_mem_write;
    assign mem.mem_addr       = w_mem_addr;
    assign mem.mem_write_data = r_buffer;
    assign busy               = w_mem_read | w_mem_write;
    assign done               = (r_state == c_DONE);
    assign words_done         = r_words_done;

    // ------------------------------------------------------------------
    // Datapath: pointers, counters, read buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_src        <= 32'd0;
            r_dst        <= 32'd0;
            r_buffer     <= 32'd0;
            r_remaining  <= c_CNT_ZERO;
            r_words_done <= c_CNT_ZERO;
            r_wait       <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_src        <= {src_addr[31:2], 2'b00};
                        r_dst        <= {dst_addr[31:2], 2'b00};
                        r_remaining  <= word_count;
                        r_words_done <= c_CNT_ZERO;
                        r_wait       <= '0;
                    end
                end
                c_READ: begin
                    // Memory read data has settled by the last wait cycle.
                    if (w_wait_last) begin
                        r_buffer <= mem.mem_read_data;
                        r_wait   <= '0;
                    end else begin
                        r_wait <= r_wait + c_WAIT_ONE;
                    end
                end
                c_WRITE: begin
                    r_src        <= r_src + 32'd4;
                    r_dst        <= r_dst + 32'd4;
                    r_words_done <= r_words_done + c_CNT_ONE;
                    r_remaining  <= r_remaining - c_CNT_ONE;
                end
                default: begin
                    r_wait <= '0;
                end
            endcase
        end
    end

`ifdef MEM_COPY_DMA_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_checksum <= 32'd0;
        end else if (w_accept) begin
            r_checksum <= 32'd0;
        end else if (r_state == c_WRITE) begin
            r_checksum <= r_checksum + r_buffer;
        end
    end

    assign checksum = r_checksum;
`else
    logic w_unused_accept;
    assign w_unused_accept = w_accept;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_dma.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_copy_dma
// Description : Directed self-checking bench for mem_copy_dma with a word
//               memory model and a bus protocol monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_copy_dma;
    localparam int READ_WAIT = 3;
    localparam int CNT_W     = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [CNT_W-1:0] word_count;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] words_done;
`ifdef MEM_COPY_DMA_CHECKSUM_EN
    logic [31:0]      checksum;
`endif

    mem_copy_dma_if bus ();

    mem_copy_dma #(
        .READ_WAIT (READ_WAIT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .words_done (words_done),
`ifdef MEM_COPY_DMA_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .mem        (bus.master)
    );

    always #5 clk = ~clk;

    // Word memory decoding addr[11:2]; asynchronous read, write on posedge.
    logic [31:0] mem [0:1023];
    assign bus.mem_read_data = mem[bus.mem_addr[11:2]];
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr[11:2]] = bus.mem_write_data;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    int          rd_run     = 0;
    bit          skip_run   = 1'b0;
    bit          prev_wr    = 1'b0;
    int          done_cnt   = 0;
    int          rd_cycles  = 0;
    int          wr_cycles  = 0;
    logic [31:0] rd_q[$];

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (bus.mem_read) rd_cycles++;
        if (bus.mem_write) wr_cycles++;
        if (bus.mem_read | bus.mem_write) begin
            check_eq("rd_wr_excl", {31'd0, bus.mem_read & bus.mem_write}, 32'd0);
            check_eq("addr_align", {30'd0, bus.mem_addr[1:0]}, 32'd0);
        end
        if (bus.mem_write) check_eq("wr_pulse", {31'd0, prev_wr}, 32'd0);
        prev_wr = bus.mem_write;
        if (bus.mem_read) begin
            if (rd_run == 0) rd_q.push_back(bus.mem_addr);
            rd_run++;
        end else if (rd_run != 0) begin
            if (!skip_run) check_eq("rd_len", 32'(rd_run), 32'(READ_WAIT));
            rd_run   = 0;
            skip_run = 1'b0;
        end
    end

    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [CNT_W-1:0] n);
        @(negedge clk);
        src_addr   = s;
        dst_addr   = d;
        word_count = n;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // lat = number of edges after the start edge at which done is seen; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check_idle_outputs(input string pfx);
        check_eq({pfx, "_busy"},   {31'd0, busy}, 32'd0);
        check_eq({pfx, "_done"},   {31'd0, done}, 32'd0);
        check_eq({pfx, "_wdone"},  32'(words_done), 32'd0);
        check_eq({pfx, "_rd"},     {31'd0, bus.mem_read}, 32'd0);
        check_eq({pfx, "_wr"},     {31'd0, bus.mem_write}, 32'd0);
        check_eq({pfx, "_addr"},   bus.mem_addr, 32'd0);
        check_eq({pfx, "_wdata"},  bus.mem_write_data, 32'd0);
`ifdef MEM_COPY_DMA_CHECKSUM_EN
        check_eq({pfx, "_csum"},   checksum, 32'd0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected bench to finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int dc, rc, wc;

        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        reset      = 1'b1;
        start      = 1'b0;
        src_addr   = 32'd0;
        dst_addr   = 32'd0;
        word_count = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("rst");
        reset = 1'b0;

        // Basic 4-word copy: words 50..53 -> 64..67
        mem[50] = 32'h11; mem[51] = 32'h22; mem[52] = 32'h33; mem[53] = 32'h44;
        do_start(32'h0000_00C8, 32'h0000_0100, 10'd4);
        wait_done(lat);
        check_eq("t1_lat", 32'(lat), 32'd16);
        check_eq("t1_wdone", 32'(words_done), 32'd4);
`ifdef MEM_COPY_DMA_CHECKSUM_EN
        check_eq("t1_csum", checksum, 32'hAA);
`endif
        for (int i = 0; i < 4; i++) check_eq("t1_data", mem[64+i], 32'h11 * (i + 1));
        @(negedge clk);
        check_eq("t1_done_pulse", {31'd0, done}, 32'd0);
        check_eq("t1_busy_end", {31'd0, busy}, 32'd0);

        // Zero count: immediate done, no bus activity
        rc = rd_cycles; wc = wr_cycles;
        do_start(32'h0000_0400, 32'h0000_0500, 10'd0);
        wait_done(lat);
        check_eq("t2_lat", 32'(lat), 32'd0);
        check_eq("t2_wdone", 32'(words_done), 32'd0);
        repeat (2) @(negedge clk);
        check_eq("t2_rd", 32'(rd_cycles - rc), 32'd0);
        check_eq("t2_wr", 32'(wr_cycles - wc), 32'd0);
        check_eq("t2_mem", mem[320], 32'd0);

        // Start while busy is ignored
        mem[100] = 32'hA5A5_A5A5; mem[101] = 32'h5A5A_5A5A;
        mem[110] = 32'hCAFE_F00D; mem[300] = 32'hDEAD_BEEF;
        dc = done_cnt;
        do_start(32'd400, 32'd800, 10'd2);
        repeat (4) @(negedge clk);
        do_start(32'd440, 32'd1200, 10'd1);
        wait_done(lat);
        check_eq("t3_lat", 32'(lat), 32'd3);
        repeat (20) @(negedge clk);
        check_eq("t3_ndone", 32'(done_cnt - dc), 32'd1);
        check_eq("t3_w0", mem[200], 32'hA5A5_A5A5);
        check_eq("t3_w1", mem[201], 32'h5A5A_5A5A);
        check_eq("t3_untouched", mem[300], 32'hDEAD_BEEF);
        check_eq("t3_wdone", 32'(words_done), 32'd2);

        // Reset during READ of word 2
        for (int i = 0; i < 4; i++) mem[120+i] = 32'h1000_0001 + 32'(i);
        dc = done_cnt;
        do_start(32'h0000_01E0, 32'h0000_0640, 10'd4);
        repeat (5) @(negedge clk);
        skip_run = 1'b1;
        reset    = 1'b1;
        @(negedge clk);
        check_idle_outputs("t4_abort");
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("t4_ndone", 32'(done_cnt - dc), 32'd0);
        check_eq("t4_w0", mem[400], 32'h1000_0001);
        for (int i = 1; i < 4; i++) check_eq("t4_untouched", mem[400+i], 32'd0);
        do_start(32'h0000_01E8, 32'h0000_0668, 10'd2);
        wait_done(lat);
        check_eq("t4_re_lat", 32'(lat), 32'd8);
        check_eq("t4_re_w0", mem[410], 32'h1000_0003);
        check_eq("t4_re_w1", mem[411], 32'h1000_0004);

        // Unaligned source near the top of the address space
        mem[1022] = 32'h1111_AAAA; mem[1023] = 32'h2222_BBBB;
        rd_q.delete();
        do_start(32'hFFFF_FFFB, 32'h0000_07D0, 10'd2);
        wait_done(lat);
        check_eq("t5_lat", 32'(lat), 32'd8);
        check_eq("t5_nrd", 32'(rd_q.size()), 32'd2);
        check_eq("t5_ra0", rd_q[0], 32'hFFFF_FFF8);
        check_eq("t5_ra1", rd_q[1], 32'hFFFF_FFFC);
        check_eq("t5_w0", mem[500], 32'h1111_AAAA);
        check_eq("t5_w1", mem[501], 32'h2222_BBBB);

        // Pointer wraps through zero
        mem[0] = 32'h33; mem[1] = 32'h44;
        rd_q.delete();
        do_start(32'hFFFF_FFFC, 32'h0000_0800, 10'd3);
        wait_done(lat);
        check_eq("t6_lat", 32'(lat), 32'd12);
        check_eq("t6_nrd", 32'(rd_q.size()), 32'd3);
        check_eq("t6_ra0", rd_q[0], 32'hFFFF_FFFC);
        check_eq("t6_ra1", rd_q[1], 32'h0000_0000);
        check_eq("t6_ra2", rd_q[2], 32'h0000_0004);
        check_eq("t6_w0", mem[512], 32'h2222_BBBB);
        check_eq("t6_w1", mem[513], 32'h33);
        check_eq("t6_w2", mem[514], 32'h44);
`ifdef MEM_COPY_DMA_CHECKSUM_EN
        check_eq("t6_csum", checksum, 32'h2222_BC32);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
